pq_shift_array: RTL and testbench
=================================

PQ_SHIFT_ARRAY -- requirements
Module: pq_shift_array

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue slots (at least 2).
REQ-002 SHALL have parameter DW, default 16, key width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port enq, input, 1, enqueue request from the control node for the current cycle.
REQ-006 SHALL have port deq, input, 1, dequeue request from the control node for the current cycle.
REQ-007 SHALL have port din, input, DW, key to enqueue; sampled when enq=1.
REQ-008 SHALL have port dout, output, DW, smallest stored key (slot 0); 0 when empty.
REQ-009 SHALL have port empty, output, 1, high when count=0.
REQ-010 SHALL have port full, output, 1, high when count=DEPTH.
REQ-011 SHALL have port count, output, $clog2(DEPTH+1), number of valid entries.
REQ-012 SHALL have port ovf, output, 1, sticky flag: an enqueue was dropped.
REQ-013 SHALL have port unf, output, 1, sticky flag: a dequeue was ignored.

Function
REQ-014 SHALL hold entries in slots 0..DEPTH-1, sorted ascending by unsigned key, valid slots contiguous from slot 0.
REQ-015 SHALL drive dout, empty, full and count combinationally from registered state only; there is no combinational path from enq/deq/din.
REQ-016 SHALL, on enq only (not full), insert din at the lowest slot i where slot i is invalid or din < key[i]; slots i..count-1 shift up one; count +1.
REQ-017 SHALL break equal-key ties FIFO: a new key is placed after all existing equal keys.
REQ-018 SHALL, on deq only (not empty), discard slot 0, shift all slots down one, invalidate the top slot, and decrement count by 1.
REQ-019 SHALL, on enq and deq in the same cycle when not empty, behave as dequeue-then-insert within one cycle: the old slot 0 is removed, din is placed in sorted order, and count is unchanged; this also applies when full.
REQ-020 SHALL, on enq and deq in the same cycle when empty, perform the enqueue only, set unf, and make count 1.
REQ-021 SHALL ignore enq alone when full, leave the contents unchanged, and set ovf.
REQ-022 SHALL ignore deq alone when empty and set unf.
REQ-023 SHALL make an enqueued key visible on dout the cycle after the enq edge, giving a latency of 1.
REQ-024 SHALL hold all state when enq=0 and deq=0.
REQ-025 SHALL clear ovf and unf only by rst.

Reset
REQ-026 SHALL, while rst=1, immediately force the following without waiting for clk: all valid bits 0, keys 0, count 0, dout 0, empty 1, full 0, ovf 0, unf 0.
REQ-027 SHALL abandon any enq/deq in the cycle rst asserts; the first operation is accepted on the first clk edge after rst deasserts.

Structure
REQ-028 SHALL take DEPTH, DW, the count width and the typedef key_t (logic [DW-1:0]) from a shared package pq_pkg.
REQ-029 SHALL build each slot as an instance of sub-module pq_cell; each cell holds a valid bit and a key, compares against din, and selects hold, load din, take the lower neighbour or take the upper neighbour.
REQ-030 SHALL compute the insert position as a one-hot vector from the per-cell "din < key or invalid" compare results plus the lower-neighbour terms; there is no priority encoder across the array.

Verification
REQ-031 SHALL cover: after reset, enq 5,3,9,3 on consecutive cycles -> dout 5,3,3,3; count 4; then four deq cycles -> dout sequence 3,3,5,9, then empty=1 and dout=0.
REQ-032 SHALL cover: fill with 1..8 (DEPTH=8) -> full=1; enq 0 alone -> ignored, ovf=1, dout=1; then enq 0 with deq -> dout=0, count=8.
REQ-033 SHALL cover: when empty, deq -> unf=1, count stays 0; enq 7 with deq -> count=1, dout=7.
REQ-034 SHALL cover: contents {2,4,6}, enq 5 with deq -> contents {4,5,6}, dout=4, count=3.
REQ-035 SHALL cover: with count=5, assert rst asynchronously mid-cycle -> count=0, empty=1, ovf=0 and unf=0 before the next clk edge.
REQ-036 SHALL cover: a random enq/deq stream of 10k cycles checked against a sorted-list reference model -> dout and count match every cycle.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared sizing, key type and per-cell next-state selector for the shift-array priority queue.
package pq_pkg;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef logic [DW-1:0] key_t;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_DIN,
    SEL_LOWER,
    SEL_UPPER
  } cell_sel_e;
endpackage

// File: rtl/pq_cell.sv
// One queue slot: a valid bit and a key, with a local compare against din and a
// four-way next-state select (hold / load din / take lower / take upper neighbour).
module pq_cell #(
  parameter int unsigned DW    = pq_pkg::DW,
  parameter bit          FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din_i,
  input  logic          enq_i,
  input  logic          deq_i,
  input  logic          hit_lo_i,
  input  logic          hit_hi_i,
  input  logic          lo_valid_i,
  input  logic [DW-1:0] lo_key_i,
  input  logic          hi_valid_i,
  input  logic [DW-1:0] hi_key_i,
  output logic          hit_o,
  output logic          valid_o,
  output logic [DW-1:0] key_o
);
  import pq_pkg::*;

  logic          valid_q, valid_d;
  logic [DW-1:0] key_q, key_d;
  cell_sel_e     sel;

  // Hits form a thermometer (0..0 1..1) across the sorted array, so the insert slot
  // is just the 0->1 edge seen by each cell against its neighbours. On a combined
  // dequeue+enqueue the array is viewed pre-shifted down, hence the use of hit_hi_i.
  always_comb begin
    hit_o = !valid_q || (din_i < key_q);
    sel   = SEL_HOLD;
    if (enq_i && !deq_i) begin
      if (hit_lo_i)   sel = SEL_LOWER;
      else if (hit_o) sel = SEL_DIN;
    end else if (deq_i && !enq_i) begin
      sel = SEL_UPPER;
    end else if (enq_i && deq_i) begin
      if (!hit_hi_i)            sel = SEL_UPPER;
      else if (FIRST || !hit_o) sel = SEL_DIN;
    end
  end

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    unique case (sel)
      SEL_DIN:   begin valid_d = 1'b1;       key_d = din_i;    end
      SEL_LOWER: begin valid_d = lo_valid_i; key_d = lo_key_i; end
      SEL_UPPER: begin valid_d = hi_valid_i; key_d = hi_key_i; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      key_q   <= '0;
    end else begin
      valid_q <= valid_d;
      key_q   <= key_d;
    end
  end

  assign valid_o = valid_q;
  assign key_o   = key_q;
endmodule

// File: rtl/pq_shift_array.sv
// Sorted shift-array priority queue: smallest key on dout, FIFO order among equal keys,
// single-cycle enqueue/dequeue/replace, sticky overflow and underflow flags.
module pq_shift_array #(
  parameter int unsigned DEPTH = pq_pkg::DEPTH,
  parameter int unsigned DW    = pq_pkg::DW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq,
  input  logic                         deq,
  input  logic [DW-1:0]                din,
  output logic [DW-1:0]                dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf,
  output logic                         unf
);
  import pq_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             do_enq, do_deq;

  logic [DEPTH-1:0] hit, valid;
  logic [DW-1:0]    key [DEPTH];
  logic [DEPTH+1:0] hit_x, valid_x;
  logic [DW-1:0]    key_x [DEPTH+2];

  // Padded neighbour views: below slot 0 never hits; above the top slot is an empty slot.
  assign hit_x   = {1'b1, hit, 1'b0};
  assign valid_x = {1'b0, valid, 1'b0};

  always_comb begin
    key_x[0]       = '0;
    key_x[DEPTH+1] = '0;
    for (int unsigned i = 0; i < DEPTH; i++) key_x[i+1] = key[i];
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Enqueue into a full queue is only legal when a dequeue frees slot 0 in the same cycle.
  assign do_deq = deq & ~empty;
  assign do_enq = enq & (~full | deq);

  always_comb begin
    count_d = count_q + CNT_W'(do_enq) - CNT_W'(do_deq);
    ovf_d   = ovf_q | (enq & ~deq & full);
    unf_d   = unf_q | (deq & empty);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    pq_cell #(
      .DW   (DW),
      .FIRST(i == 0)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .din_i     (din),
      .enq_i     (do_enq),
      .deq_i     (do_deq),
      .hit_lo_i  (hit_x[i]),
      .hit_hi_i  (hit_x[i+2]),
      .lo_valid_i(valid_x[i]),
      .lo_key_i  (key_x[i]),
      .hi_valid_i(valid_x[i+2]),
      .hi_key_i  (key_x[i+2]),
      .hit_o     (hit[i]),
      .valid_o   (valid[i]),
      .key_o     (key[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign dout  = valid[0] ? key[0] : '0;
  assign count = count_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
endmodule

// File: tb/tb_pq_shift_array.sv
// Scoreboard bench for pq_shift_array: directed scenarios plus a long random stream,
// checked every cycle against a sorted-queue reference model.
module tb_pq_shift_array;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enq = 1'b0;
  logic          deq = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          empty, full, ovf, unf;
  logic [3:0]    count;

  pq_shift_array #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .enq  (enq),
    .deq  (deq),
    .din  (din),
    .dout (dout),
    .empty(empty),
    .full (full),
    .count(count),
    .ovf  (ovf),
    .unf  (unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned dout;
    int unsigned cnt;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t        sb[$];
  int unsigned mq[$];
  bit          m_ovf, m_unf;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  // Reference: remove the head first (if asked and possible), then insert after equal keys.
  function automatic void model_step(bit e, bit d, int unsigned x);
    bit was_full = (mq.size() == DEPTH);
    int p;
    if (d) begin
      if (mq.size() == 0) m_unf = 1'b1;
      else void'(mq.pop_front());
    end
    if (e) begin
      if (!d && was_full) m_ovf = 1'b1;
      else begin
        p = mq.size();
        foreach (mq[i]) if (x < mq[i]) begin p = i; break; end
        mq.insert(p, x);
      end
    end
  endfunction

  task automatic step(input bit e, input bit d, input int unsigned x);
    exp_t ex;
    @(negedge clk);
    enq = e;
    deq = d;
    din = DW'(x);
    model_step(e, d, x);
    ex.dout = (mq.size() == 0) ? 0 : mq[0];
    ex.cnt  = mq.size();
    ex.ovf  = m_ovf;
    ex.unf  = m_unf;
    sb.push_back(ex);
  endtask

  task automatic idle();
    step(0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle, so one expectation retires per edge.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
        ex = sb.pop_front();
        chk("sb_dout",  32'(dout),  32'(ex.dout));
        chk("sb_count", 32'(count), 32'(ex.cnt));
        chk("sb_ovf",   32'(ovf),   32'(ex.ovf));
        chk("sb_unf",   32'(unf),   32'(ex.unf));
        chk("sb_empty", 32'(empty), 32'(ex.cnt == 0));
        chk("sb_full",  32'(full),  32'(ex.cnt == DEPTH));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pe;
    int unsigned k;
    model_reset();
    #1;
    chk("rst_dout",  32'(dout),  32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", 32'({ovf, unf}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // enq 5,3,9,3 then drain
    step(1, 0, 5); step(1, 0, 3); step(1, 0, 9); step(1, 0, 3);
    idle();
    chk("r31_count", 32'(count), 32'd4);
    chk("r31_dout",  32'(dout),  32'd3);
    repeat (4) step(0, 1, 0);
    idle();
    chk("r31_empty", 32'(empty), 32'd1);
    chk("r31_dout0", 32'(dout),  32'd0);

    // fill, overflow, replace-when-full
    for (int unsigned i = 1; i <= DEPTH; i++) step(1, 0, i);
    idle();
    chk("r32_full", 32'(full), 32'd1);
    step(1, 0, 0);
    idle();
    chk("r32_ovf",  32'(ovf),  32'd1);
    chk("r32_dout", 32'(dout), 32'd1);
    step(1, 1, 0);
    idle();
    chk("r32_rdout",  32'(dout),  32'd0);
    chk("r32_rcount", 32'(count), 32'd8);

    // underflow and enq+deq on empty
    repeat (DEPTH) step(0, 1, 0);
    step(0, 1, 0);
    idle();
    chk("r33_unf",   32'(unf),   32'd1);
    chk("r33_count", 32'(count), 32'd0);
    step(1, 1, 7);
    idle();
    chk("r33_count1", 32'(count), 32'd1);
    chk("r33_dout",   32'(dout),  32'd7);

    // {2,4,6} replace with 5
    step(0, 1, 0);
    step(1, 0, 2); step(1, 0, 4); step(1, 0, 6);
    step(1, 1, 5);
    idle();
    chk("r34_dout",  32'(dout),  32'd4);
    chk("r34_count", 32'(count), 32'd3);

    // async reset mid-cycle with count=5 and both flags set
    step(1, 0, 1); step(1, 0, 2);
    idle();
    chk("r35_pre", 32'(count), 32'd5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("r35_count", 32'(count), 32'd0);
    chk("r35_empty", 32'(empty), 32'd1);
    chk("r35_ovf",   32'(ovf),   32'd0);
    chk("r35_unf",   32'(unf),   32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // random stream with shifting enqueue bias to visit full and empty often
    pe = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 400 == 0) pe = (c / 400) % 3 == 0 ? 80 : ((c / 400) % 3 == 1 ? 20 : 50);
      k = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF) : $urandom_range(0, 20);
      step($urandom_range(0, 99) < pe, $urandom_range(0, 99) < (100 - pe), k);
    end
    idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
